sequenciador_varredura: RTL and testbench

//   Upstream scan sequencer for the 3-to-8 decoder (decodificadorbcd). Drives the decoder's
//   3-bit address A and its enable, stepping through outputs 0..LAST on a prescaled timebase.
//   A blanking gap holds enable low so A only ever changes while the decoder is disabled.

---
 rtl/sequenciador_varredura.sv | 114 +++++++++++
 tb/tb_sequenciador_varredura.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_varredura.sv
// ---------------------------------------------------------------------------
// sequenciador_varredura: scan sequencer driving a 3-to-8 decoder address and enable
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sequenciador_varredura #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1,
  parameter int LAST     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  output logic [2:0] A,
  output logic       enable,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] PS_END = 8'(PRESCALE - 1);
  localparam logic [7:0] BL_END = 8'(BLANK - 1);
  localparam logic [2:0] A_LAST = 3'(LAST);

  state_t     state;
  logic [7:0] cnt;
  logic       at_last;
  logic [2:0] a_next;

  assign at_last = (A == A_LAST);
  assign a_next  = at_last ? 3'd0 : A + 3'd1;

  // One counter serves both the ON slot length and the GAP length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      A      <= 3'd0;
      enable <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          enable <= 1'b0;
          cnt    <= 8'd0;
          if (run) begin
            state  <= ON;
            enable <= 1'b1;
          end else if (step) begin
            A    <= a_next;
            wrap <= at_last;
          end
        end

        ON: begin
          if (cnt == PS_END) begin
            A    <= a_next;
            wrap <= at_last;
            cnt  <= 8'd0;
            if (BLANK > 0) begin
              state  <= GAP;
              enable <= 1'b0;
            end else if (run) begin
              state  <= ON;
              enable <= 1'b1;
            end else begin
              state  <= IDLE;
              enable <= 1'b0;
            end
          end else if (!run) begin
            // Abandon the slot without advancing so resume replays this address.
            state  <= IDLE;
            enable <= 1'b0;
            cnt    <= 8'd0;
          end else begin
            cnt    <= cnt + 8'd1;
            enable <= 1'b1;
          end
        end

        GAP: begin
          enable <= 1'b0;
          if (cnt == BL_END) begin
            cnt <= 8'd0;
            if (run) begin
              state  <= ON;
              enable <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= 8'd0;
          enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_varredura.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_varredura: directed scoreboard bench for the scan sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sequenciador_varredura;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       run2;
  logic       step2;
  logic [2:0] a1;
  logic       en1;
  logic       wr1;
  logic [2:0] a2;
  logic       en2;
  logic       wr2;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];

  sequenciador_varredura dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .A(a1), .enable(en1), .wrap(wr1)
  );

  sequenciador_varredura #(.PRESCALE(4), .BLANK(0), .LAST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2), .step(step2),
    .A(a2), .enable(en2), .wrap(wr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [2:0] a, input logic en, input logic wr, input string tag);
    exp_t e;
    e.v   = {a, en, wr};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [4:0] act);
    exp_t e;
    e = q.pop_front();
    compared++;
    assert (act === e.v) else begin
      mismatched++;
      $error("FAIL %s: observed A/en/wrap=%b expected %b", e.tag, act, e.v);
    end
  endtask

  task automatic now1(input logic [2:0] a, input logic en, input logic wr, input string tag);
    push(a, en, wr, tag);
    pop_cmp({a1, en1, wr1});
  endtask

  task automatic cyc(input logic [2:0] a, input logic en, input logic wr, input string tag);
    push(a, en, wr, tag);
    @(posedge clk);
    #1;
    pop_cmp({a1, en1, wr1});
  endtask

  task automatic cyc2(input logic [2:0] a, input logic en, input logic wr, input string tag);
    push(a, en, wr, tag);
    @(posedge clk);
    #1;
    pop_cmp({a2, en2, wr2});
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    run2  = 1'b0;
    step2 = 1'b0;
    #3;
    now1(3'd0, 1'b0, 1'b0, "reset_state");
    cyc(3'd0, 1'b0, 1'b0, "reset_held");
    rst_n = 1'b1;
    run   = 1'b1;

    // Free run: two full periods, 4 cycles on, 1 gap, wrap on 7->0
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 8; a++) begin
        for (int c = 0; c < 4; c++) cyc(3'(a), 1'b1, 1'b0, "freerun_on");
        cyc(3'((a + 1) % 8), 1'b0, (a == 7), "freerun_gap");
      end
    end

    // Advance into the A=5 slot, then assert reset asynchronously mid-slot
    for (int a = 0; a < 5; a++) begin
      for (int c = 0; c < 4; c++) cyc(3'(a), 1'b1, 1'b0, "pre_reset_on");
      cyc(3'(a + 1), 1'b0, 1'b0, "pre_reset_gap");
    end
    cyc(3'd5, 1'b1, 1'b0, "pre_reset_a5");
    cyc(3'd5, 1'b1, 1'b0, "pre_reset_a5");
    #2;
    rst_n = 1'b0;
    #1;
    now1(3'd0, 1'b0, 1'b0, "async_reset");
    @(posedge clk);
    #1;
    now1(3'd0, 1'b0, 1'b0, "reset_over_edge");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cyc(3'd0, 1'b1, 1'b0, "post_reset_slot0");
    cyc(3'd1, 1'b0, 1'b0, "post_reset_gap");

    // Pause in the 2nd ON cycle of A=3, then resume with a full slot
    for (int a = 1; a < 3; a++) begin
      for (int c = 0; c < 4; c++) cyc(3'(a), 1'b1, 1'b0, "to_a3_on");
      cyc(3'(a + 1), 1'b0, 1'b0, "to_a3_gap");
    end
    cyc(3'd3, 1'b1, 1'b0, "a3_on_c0");
    cyc(3'd3, 1'b1, 1'b0, "a3_on_c1");
    run = 1'b0;
    cyc(3'd3, 1'b0, 1'b0, "pause_idle");
    cyc(3'd3, 1'b0, 1'b0, "pause_hold");
    run = 1'b1;
    for (int c = 0; c < 4; c++) cyc(3'd3, 1'b1, 1'b0, "resume_full_slot");
    cyc(3'd4, 1'b0, 1'b0, "resume_advance");

    // Run up to A=6, then pause and single-step across the wrap
    for (int c = 0; c < 4; c++) cyc(3'd4, 1'b1, 1'b0, "to_a6_on");
    cyc(3'd5, 1'b0, 1'b0, "to_a6_gap");
    for (int c = 0; c < 4; c++) cyc(3'd5, 1'b1, 1'b0, "to_a6_on");
    cyc(3'd6, 1'b0, 1'b0, "to_a6_gap");
    run = 1'b0;
    cyc(3'd6, 1'b0, 1'b0, "idle_a6");
    step = 1'b1; cyc(3'd7, 1'b0, 1'b0, "step_to_7");
    step = 1'b0; cyc(3'd7, 1'b0, 1'b0, "step_hold_7");
    step = 1'b1; cyc(3'd0, 1'b0, 1'b1, "step_wrap_0");
    step = 1'b0; cyc(3'd0, 1'b0, 1'b0, "step_hold_0");
    step = 1'b1; cyc(3'd1, 1'b0, 1'b0, "step_to_1");
    step = 1'b0; cyc(3'd1, 1'b0, 1'b0, "step_hold_1");
    step = 1'b1; cyc(3'd2, 1'b0, 1'b0, "step_to_2");
    step = 1'b0; cyc(3'd2, 1'b0, 1'b0, "step_hold_2");

    // run and step together in IDLE: run wins, no advance
    run  = 1'b1;
    step = 1'b1;
    cyc(3'd2, 1'b1, 1'b0, "run_step_together");
    step = 1'b0;
    for (int c = 0; c < 3; c++) cyc(3'd2, 1'b1, 1'b0, "run_step_slot");
    cyc(3'd3, 1'b0, 1'b0, "run_step_advance");
    run = 1'b0;
    cyc(3'd3, 1'b0, 1'b0, "stop_idle");

    // BLANK=0, LAST=2 instance: enable continuous, wrap on 2->0
    cyc2(3'd0, 1'b0, 1'b0, "b0_idle");
    run2 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 3; a++) begin
        for (int c = 0; c < 4; c++)
          cyc2(3'(a), 1'b1, (p > 0 && a == 0 && c == 0), "b0_scan");
      end
    end
    cyc2(3'd0, 1'b1, 1'b1, "b0_wrap");
    cyc2(3'd0, 1'b1, 1'b0, "b0_after_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
